// File: rtl/oc_rf_pkg.sv
// Shared definitions for the register-bank read path: bank count, tag width,
// queued request record and the warp/register to bank/row mapping.
package oc_rf_pkg;

   localparam int NUM_BANKS = 4;
   localparam int OCID_W    = 3;
   localparam int ROW_W     = 6;

   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [OCID_W-1:0] ocid;
   } oc_req_t;

   // Warps are skewed across banks so that the same register of
   // neighbouring warps lands in different banks.
   function automatic logic [1:0] bank_of(input logic [2:0] warp, input logic [4:0] reg_idx);
      return reg_idx[1:0] + warp[1:0];
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [2:0] warp, input logic [4:0] reg_idx);
      return {warp, reg_idx[4:2]};
   endfunction

endpackage

// File: rtl/oc_bank_req_fifo.sv
// Per-bank request FIFO: up to two pushes and one pop per cycle.
// Port A is ordered ahead of port B when both push in the same cycle.
module oc_bank_req_fifo
   import oc_rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_a_i,
   input  oc_req_t data_a_i,
   input  logic    push_b_i,
   input  oc_req_t data_b_i,
   input  logic    pop_i,
   output oc_req_t head_o,
   output logic    empty_o,
   output logic    room2_o
);

   localparam int PTR_W = $clog2(DEPTH);

   oc_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_b_ptr;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W:0]   n_push;
   logic [PTR_W+1:0] fill_after_push;

   assign n_push          = (PTR_W+1)'(push_a_i) + (PTR_W+1)'(push_b_i);
   // Port B lands directly behind port A, or in A's slot when A is idle.
   assign wr_b_ptr        = wr_ptr_q + PTR_W'(push_a_i);
   assign wr_ptr_d        = wr_ptr_q + n_push[PTR_W-1:0];
   assign rd_ptr_d        = rd_ptr_q + PTR_W'(pop_i);
   assign count_d         = count_q + n_push - (PTR_W+1)'(pop_i);
   assign fill_after_push = {1'b0, count_q} + {1'b0, n_push};

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign room2_o = (count_q <= (PTR_W+1)'(DEPTH - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
      if (push_b_i) mem_q[wr_b_ptr] <= data_b_i;
   end

   // Upstream only accepts with two free slots, so overflow means a broken Req_Ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (fill_after_push <= (PTR_W+2)'(DEPTH));
         assert (!(pop_i && empty_o));
      end
   end

endmodule

// File: rtl/oc_bank_read_dispatch.sv
// Register-bank read dispatch: per-bank request queues, one read per bank per cycle,
// tagged return to the collectors. OC_BANK_BYPASS_EN enables same-cycle FIFO bypass.
module oc_bank_read_dispatch
   import oc_rf_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic [2:0]        WarpID_Req,
   input  logic              Src1_Valid,
   input  logic [4:0]        Src1_Reg,
   input  logic [2:0]        Src1_OCID,
   input  logic              Src2_Valid,
   input  logic [4:0]        Src2_Reg,
   input  logic [2:0]        Src2_OCID,
   input  logic [3:0]        WB_Bank_Busy,
   output logic              RdEn_0,
   output logic [ADDR_W-1:0] RdAddr_0,
   input  logic [DATA_W-1:0] RdData_0,
   output logic [DATA_W-1:0] DataOut_0,
   output logic [3:0]        ocid_0,
   output logic              RdEn_1,
   output logic [ADDR_W-1:0] RdAddr_1,
   input  logic [DATA_W-1:0] RdData_1,
   output logic [DATA_W-1:0] DataOut_1,
   output logic [3:0]        ocid_1,
   output logic              RdEn_2,
   output logic [ADDR_W-1:0] RdAddr_2,
   input  logic [DATA_W-1:0] RdData_2,
   output logic [DATA_W-1:0] DataOut_2,
   output logic [3:0]        ocid_2,
   output logic              RdEn_3,
   output logic [ADDR_W-1:0] RdAddr_3,
   input  logic [DATA_W-1:0] RdData_3,
   output logic [DATA_W-1:0] DataOut_3,
   output logic [3:0]        ocid_3
);

   // Handshake: a request transfers on a cycle where Req_Valid and Req_Ready are both 1.
   // Req_Ready is a function of FIFO occupancy only, never of the request fields.
   logic                 accept;
   logic [1:0]           bank1, bank2;
   oc_req_t              req1, req2;
   logic [NUM_BANKS-1:0] room2;

   assign accept = Req_Valid & Req_Ready;
   assign bank1  = bank_of(WarpID_Req, Src1_Reg);
   assign bank2  = bank_of(WarpID_Req, Src2_Reg);
   assign req1   = '{row: row_of(WarpID_Req, Src1_Reg), ocid: Src1_OCID};
   assign req2   = '{row: row_of(WarpID_Req, Src2_Reg), ocid: Src2_OCID};

   assign Req_Ready = &room2;

   for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      logic              hit1, hit2, bypass;
      logic              push_a, push_b, pop, empty;
      logic              rd_en;
      logic [ADDR_W-1:0] rd_addr;
      oc_req_t           head, issue;
      logic [OCID_W:0]   tag_q, tag_d;

      assign hit1 = accept & Src1_Valid & (bank1 == 2'(k));
      assign hit2 = accept & Src2_Valid & (bank2 == 2'(k));

`ifdef OC_BANK_BYPASS_EN
      // Only a lone source may skip an idle, empty bank; a same-bank pair queues in order.
      assign bypass = empty & ~WB_Bank_Busy[k] & (hit1 ^ hit2);
`else
      assign bypass = 1'b0;
`endif

      assign push_a = hit1 & ~bypass;
      assign push_b = hit2 & ~bypass;
      assign pop    = ~empty & ~WB_Bank_Busy[k];

      oc_bank_req_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push_a_i (push_a),
         .data_a_i (req1),
         .push_b_i (push_b),
         .data_b_i (req2),
         .pop_i    (pop),
         .head_o   (head),
         .empty_o  (empty),
         .room2_o  (room2[k])
      );

      assign issue   = bypass ? (hit1 ? req1 : req2) : head;
      assign rd_en   = pop | bypass;
      assign rd_addr = rd_en ? ADDR_W'(issue.row) : '0;
      assign tag_d   = rd_en ? {1'b1, issue.ocid} : '0;

      always_ff @(posedge clk) begin
         if (rst) tag_q <= '0;
         else     tag_q <= tag_d;
      end
   end

   assign RdEn_0    = g_bank[0].rd_en;
   assign RdAddr_0  = g_bank[0].rd_addr;
   assign ocid_0    = g_bank[0].tag_q;
   assign DataOut_0 = RdData_0;

   assign RdEn_1    = g_bank[1].rd_en;
   assign RdAddr_1  = g_bank[1].rd_addr;
   assign ocid_1    = g_bank[1].tag_q;
   assign DataOut_1 = RdData_1;

   assign RdEn_2    = g_bank[2].rd_en;
   assign RdAddr_2  = g_bank[2].rd_addr;
   assign ocid_2    = g_bank[2].tag_q;
   assign DataOut_2 = RdData_2;

   assign RdEn_3    = g_bank[3].rd_en;
   assign RdAddr_3  = g_bank[3].rd_addr;
   assign ocid_3    = g_bank[3].tag_q;
   assign DataOut_3 = RdData_3;

endmodule
